register_bank_ctrl: RTL and testbench

- Parametrised successor to the 8x8 CPU register bank.
- Adds an asynchronous clear and a handshaked, registered bus-read port.
- Indirect reads run as a two-step pipelined fetch with write forwarding.
- Keeps the combinational rx/ry operand ports for the ALU datapath; the bus-read side is driven by the control unit through a valid/ready handshake.

---
 rtl/register_bank_ctrl_if.sv | 43 ++++
 rtl/register_bank_ctrl.sv | 119 +++++++++++
 tb/tb_register_bank_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/register_bank_ctrl_if.sv
// Bus bundle for register_bank_ctrl.
// Groups the write port, the handshaked bus-read port and the
// combinational operand ports.
//   slave  : register bank side (samples write/read requests, drives results)
//   master : control unit / datapath side
interface register_bank_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    // write port
    logic              wr_en;
    logic [ADDR_W-1:0] wr_sel;
    logic [DATA_W-1:0] wr_data;
    // handshaked bus-read port
    logic              rd_req;
    logic [ADDR_W-1:0] rd_sel;
    logic              rd_indirect;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    // combinational operand ports
    logic [ADDR_W-1:0] rx_sel;
    logic [ADDR_W-1:0] ry_sel;
    logic [DATA_W-1:0] rx_data;
    logic [DATA_W-1:0] ry_data;

    modport slave (
        input  wr_en, wr_sel, wr_data,
        input  rd_req, rd_sel, rd_indirect, rd_ready,
        output rd_valid, rd_data, busy,
        input  rx_sel, ry_sel,
        output rx_data, ry_data
    );

    modport master (
        output wr_en, wr_sel, wr_data,
        output rd_req, rd_sel, rd_indirect, rd_ready,
        input  rd_valid, rd_data, busy,
        output rx_sel, ry_sel,
        input  rx_data, ry_data
    );
endinterface

// File: rtl/register_bank_ctrl.sv
// Parametrised CPU register bank (2**ADDR_W registers of DATA_W bits).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears the array to RESET_VAL
//           and drops any bus read in flight
//   bus   - register_bank_ctrl_if.slave:
//           write port (wr_en/wr_sel/wr_data), accepted every cycle;
//           bus-read port (rd_req/rd_sel/rd_indirect -> rd_valid/rd_data,
//           rd_ready accepts), busy while a read is in progress;
//           operand ports rx/ry, combinational reads of the stored array.
module register_bank_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic clk,
    input logic rst_n,
    register_bank_ctrl_if.slave bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        HOLD
    } state_t;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [ADDR_W-1:0] fetch_idx;
    logic [DATA_W-1:0] fetch_val;

    // Register array: one write per cycle, never blocked by the read FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (bus.wr_en) begin
            regs_q[bus.wr_sel] <= bus.wr_data;
        end
    end

    // One shared read port serves the direct capture, the pointer fetch
    // (both in IDLE, indexed by rd_sel) and the PTR-stage capture (indexed
    // by the latched pointer). A same-cycle write to that index wins.
    always_comb begin
        fetch_idx = (state_q == PTR) ? ptr_q : bus.rd_sel;
        if (bus.wr_en && (bus.wr_sel == fetch_idx)) begin
            fetch_val = bus.wr_data;
        end else begin
            fetch_val = regs_q[fetch_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rd_req) begin
                    if (bus.rd_indirect) begin
                        // only the low ADDR_W bits of the pointer register matter
                        ptr_d   = fetch_val[ADDR_W-1:0];
                        state_d = PTR;
                    end else begin
                        rd_data_d  = fetch_val;
                        rd_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            PTR: begin
                rd_data_d  = fetch_val;
                rd_valid_d = 1'b1;
                state_d    = HOLD;
            end
            HOLD: begin
                // rd_data_q is left untouched here, so writes cannot disturb it
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.rx_data  = regs_q[bus.rx_sel];
    assign bus.ry_data  = regs_q[bus.ry_sel];

endmodule

// File: tb/tb_register_bank_ctrl.sv
module tb_register_bank_ctrl;
    localparam int NR = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    register_bank_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus0 ();
    register_bank_ctrl #(.DATA_W(8), .ADDR_W(3), .RESET_VAL(8'h00)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    register_bank_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus1 ();
    register_bank_ctrl #(.DATA_W(16), .ADDR_W(4), .RESET_VAL(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register contents, outstanding expected read results,
    // and whether a read is waiting for its pointer or waiting for acceptance.
    logic [7:0] mem [NR];
    logic [7:0] expq [$];
    bit         m_holding;
    bit         m_ptr_pending;
    int         m_ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fwd(input int i);
        if (bus0.wr_en && (int'(bus0.wr_sel) == i)) return bus0.wr_data;
        return mem[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem[i] = 8'h00;
        expq.delete();
        m_holding     = 0;
        m_ptr_pending = 0;
        m_ptr         = 0;
    endtask

    // Applies the rules for one rising edge, using the inputs present at it.
    task automatic model_edge();
        logic [7:0] v;
        if (!rst_n) return;
        if (m_holding) begin
            if (bus0.rd_ready) m_holding = 0;
        end else if (m_ptr_pending) begin
            expq.push_back(fwd(m_ptr));
            m_ptr_pending = 0;
            m_holding     = 1;
        end else if (bus0.rd_req) begin
            v = fwd(int'(bus0.rd_sel));
            if (bus0.rd_indirect) begin
                m_ptr         = int'(v) % NR;
                m_ptr_pending = 1;
            end else begin
                expq.push_back(v);
                m_holding = 1;
            end
        end
        if (bus0.wr_en) mem[bus0.wr_sel] = bus0.wr_data;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Monitor: checks handshake outputs and operand reads every cycle,
    // compares rd_data against the scoreboard head while valid, pops on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_valid", {31'b0, bus0.rd_valid}, {31'b0, m_holding});
            chk("busy", {31'b0, bus0.busy}, {31'b0, (m_holding || m_ptr_pending)});
            chk("rx_data", {24'b0, bus0.rx_data}, {24'b0, mem[bus0.rx_sel]});
            chk("ry_data", {24'b0, bus0.ry_data}, {24'b0, mem[bus0.ry_sel]});
            if (bus0.rd_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got rd_valid=1 with data %0h, expected no pending read", bus0.rd_data);
                end else begin
                    chk("rd_data", {24'b0, bus0.rd_data}, {24'b0, expq[0]});
                    if (bus0.rd_ready) void'(expq.pop_front());
                end
            end
        end
    end

    task automatic idle0();
        bus0.wr_en = 0; bus0.wr_sel = '0; bus0.wr_data = '0;
        bus0.rd_req = 0; bus0.rd_sel = '0; bus0.rd_indirect = 0;
    endtask

    task automatic wr0(input int sel, input logic [7:0] d);
        bus0.wr_en = 1; bus0.wr_sel = 3'(sel); bus0.wr_data = d;
    endtask

    task automatic req0(input int sel, input bit ind);
        bus0.rd_req = 1; bus0.rd_sel = 3'(sel); bus0.rd_indirect = ind;
    endtask

    initial begin
        int n;
        rst_n = 0;
        idle0();
        bus0.rd_ready = 1; bus0.rx_sel = '0; bus0.ry_sel = '0;
        bus1.wr_en = 0; bus1.wr_sel = '0; bus1.wr_data = '0;
        bus1.rd_req = 0; bus1.rd_sel = '0; bus1.rd_indirect = 0; bus1.rd_ready = 1;
        bus1.rx_sel = '0; bus1.ry_sel = '0;
        model_reset();
        repeat (2) cyc();
        chk("reset_valid", {31'b0, bus0.rd_valid}, 0);
        chk("reset_busy", {31'b0, bus0.busy}, 0);
        chk("reset_data", {24'b0, bus0.rd_data}, 0);
        rst_n = 1;
        cyc();

        // direct read, latency 1
        wr0(3, 8'hA5); cyc(); idle0();
        req0(3, 0); cyc(); idle0();
        chk("direct_valid", {31'b0, bus0.rd_valid}, 1);
        chk("direct_data", {24'b0, bus0.rd_data}, 32'hA5);
        cyc();
        chk("direct_done_valid", {31'b0, bus0.rd_valid}, 0);
        chk("direct_done_busy", {31'b0, bus0.busy}, 0);

        // indirect read, latency 2
        wr0(2, 8'h05); cyc(); wr0(5, 8'h3C); cyc(); idle0();
        req0(2, 1); cyc(); idle0();
        chk("ind_lat1_valid", {31'b0, bus0.rd_valid}, 0);
        chk("ind_lat1_busy", {31'b0, bus0.busy}, 1);
        cyc();
        chk("ind_valid", {31'b0, bus0.rd_valid}, 1);
        chk("ind_data", {24'b0, bus0.rd_data}, 32'h3C);
        cyc();
        // pointer upper bits ignored
        wr0(2, 8'hFD); cyc(); idle0();
        req0(2, 1); cyc(); idle0(); cyc();
        chk("ind_upper_data", {24'b0, bus0.rd_data}, 32'h3C);
        cyc();

        // same-cycle write forwarding, direct
        wr0(4, 8'h77); req0(4, 0); cyc(); idle0();
        chk("fwd_direct_data", {24'b0, bus0.rd_data}, 32'h77);
        cyc();
        // pointer forwarding
        wr0(6, 8'h99); cyc();
        wr0(1, 8'h06); req0(1, 1); cyc(); idle0(); cyc();
        chk("fwd_ptr_data", {24'b0, bus0.rd_data}, 32'h99);
        cyc();

        // backpressure: held data survives writes, requests during HOLD ignored
        bus0.rd_ready = 0;
        req0(5, 0); cyc(); idle0();
        for (int i = 0; i < 5; i++) begin
            wr0(5, 8'(8'h40 + i)); req0(2, 0);
            cyc();
            chk("bp_valid", {31'b0, bus0.rd_valid}, 1);
            chk("bp_data", {24'b0, bus0.rd_data}, 32'h3C);
        end
        bus0.wr_en = 0; bus0.rd_ready = 1;
        cyc();
        chk("bp_release_busy", {31'b0, bus0.busy}, 0);
        cyc(); idle0();
        chk("bp_second_data", {24'b0, bus0.rd_data}, 32'hFD);
        cyc();

        // asynchronous reset in the middle of HOLD
        bus0.rd_ready = 0; bus0.rx_sel = 3'd3; bus0.ry_sel = 3'd5;
        req0(3, 0); cyc(); idle0();
        chk("prereset_valid", {31'b0, bus0.rd_valid}, 1);
        #1;
        rst_n = 0;
        model_reset();
        #1;
        chk("async_valid", {31'b0, bus0.rd_valid}, 0);
        chk("async_busy", {31'b0, bus0.busy}, 0);
        chk("async_rx", {24'b0, bus0.rx_data}, 0);
        chk("async_ry", {24'b0, bus0.ry_data}, 0);
        cyc(); cyc();
        rst_n = 1;
        bus0.rd_ready = 1;
        cyc();
        chk("postreset_busy", {31'b0, bus0.busy}, 0);
        chk("postreset_valid", {31'b0, bus0.rd_valid}, 0);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            bus0.wr_en       = ($urandom_range(0, 1) == 1);
            bus0.wr_sel      = 3'($urandom_range(0, NR - 1));
            bus0.wr_data     = 8'($urandom);
            bus0.rd_req      = ($urandom_range(0, 2) != 0);
            bus0.rd_sel      = 3'($urandom_range(0, NR - 1));
            bus0.rd_indirect = ($urandom_range(0, 1) == 1);
            bus0.rd_ready    = ($urandom_range(0, 2) != 0);
            bus0.rx_sel      = 3'($urandom_range(0, NR - 1));
            bus0.ry_sel      = 3'($urandom_range(0, NR - 1));
            cyc();
        end
        idle0();
        bus0.rd_ready = 1;
        n = 0;
        while ((m_holding || m_ptr_pending) && n < 10) begin
            cyc();
            n++;
        end
        cyc();
        chk("drain_bound", {31'b0, (m_holding || m_ptr_pending)}, 0);
        chk("drain_queue", 32'(expq.size()), 0);

        // wider instance: DATA_W=16, ADDR_W=4
        bus1.wr_en = 1; bus1.wr_sel = 4'd15; bus1.wr_data = 16'hBEEF; cyc();
        bus1.wr_sel = 4'd0; bus1.wr_data = 16'h000F; cyc();
        bus1.wr_en = 0;
        bus1.rd_req = 1; bus1.rd_sel = 4'd0; bus1.rd_indirect = 1; cyc();
        bus1.rd_req = 0; bus1.rd_indirect = 0;
        n = 1;
        while (!bus1.rd_valid && n < 6) begin
            cyc();
            n++;
        end
        chk("w16_latency", 32'(n), 2);
        chk("w16_data", {16'b0, bus1.rd_data}, 32'hBEEF);
        bus1.rx_sel = 4'd15;
        #1;
        chk("w16_rx", {16'b0, bus1.rx_data}, 32'hBEEF);
        cyc(); cyc();
        chk("w16_done_busy", {31'b0, bus1.busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
